// File: rtl/param_updown_counter_pkg.sv
// Shared counter definitions: direction and boundary-mode encodings,
// the per-cycle count action, and a prescaler sizing helper.
package param_updown_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // What the count register does this cycle, after priority resolution.
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_UP   = 2'd2,
    ACT_DN   = 2'd3
  } act_e;

  // Width of the prescaler phase register (at least one bit).
  function automatic int unsigned presc_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_updown_counter_tick_prescaler.sv
// Enabled-cycle prescaler: counts enabled cycles 0..PRESCALE-1 and issues a
// tick on the last phase, then returns to 0. Holds while en is low.
module tick_prescaler
  import param_updown_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned   PW   = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_phase;
  logic          w_last;

  // With PRESCALE=1 LAST is 0 and the phase never leaves 0, so tick reduces to en.
  assign w_last = (r_phase == LAST);
  assign tick   = en & w_last;

  // Phase register: cleared on reset or restart, advances on enabled cycles.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_phase <= '0;
    end else if (en) begin
      r_phase <= w_last ? '0 : r_phase + 1'b1;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with modulo limit, wrap/saturate mode,
// parallel load, prescaled enable, and terminal/boundary flags.
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned SATURATE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_p,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  logic             w_tick;
  act_e             w_act;
  logic [WIDTH-1:0] w_next;
  logic             w_event;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  // Load restarts the prescaler so the first step lands PRESCALE cycles later.
  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .clk  (clk),
    .reset(reset),
    .clr  (load),
    .en   (en),
    .tick (w_tick)
  );

  // Resolve load > step priority, then compute next count and boundary event.
  always_comb begin
    w_act   = ACT_HOLD;
    w_next  = r_count;
    w_event = 1'b0;

    if (load) begin
      w_act = ACT_LOAD;
    end else if (w_tick) begin
      w_act = (up_dn == DIR_UP) ? ACT_UP : ACT_DN;
    end

    case (w_act)
      ACT_LOAD: w_next = clamp_load(load_val);
      ACT_UP: begin
        if (r_count == MAX_C) begin
          w_event = 1'b1;
          w_next  = (SATURATE == MODE_SAT) ? MAX_C : '0;
        end else begin
          w_next = r_count + 1'b1;
        end
      end
      ACT_DN: begin
        if (r_count == '0) begin
          w_event = 1'b1;
          w_next  = (SATURATE == MODE_SAT) ? '0 : MAX_C;
        end else begin
          w_next = r_count - 1'b1;
        end
      end
      default: w_next = r_count;
    endcase
  end

  // Count, boundary pulse and sticky overflow; a new event beats clr_ovf.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_wrap  <= w_event;
      r_ovf   <= w_event | (r_ovf & ~clr_ovf);
    end
  end

  assign count    = r_count;
  assign wrap_p   = r_wrap;
  assign overflow = r_ovf;
  assign tc       = (up_dn == DIR_UP) ? (r_count == MAX_C) : (r_count == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: a vector table on a wrap-mode counter (WIDTH=4, MAX=9),
// plus hand sequences for saturate mode and PRESCALE=3.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       reset, en, up_dn, load, clr_ovf;
  logic [3:0] load_val;

  logic [3:0] a_count, b_count, c_count;
  logic       a_tc, a_wrap, a_ovf;
  logic       b_tc, b_wrap, b_ovf;
  logic       c_tc, c_wrap, c_ovf;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(a_count), .tc(a_tc), .wrap_p(a_wrap), .overflow(a_ovf));

  param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(b_count), .tc(b_tc), .wrap_p(b_wrap), .overflow(b_ovf));

  param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(3), .SATURATE(0)) dut_c (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(c_count), .tc(c_tc), .wrap_p(c_wrap), .overflow(c_ovf));

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] lv;
    logic       e;
    logic       ud;
    logic       clr;
    logic [3:0] cnt;
    logic       tc;
    logic       wr;
    logic       ov;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic ld, input logic [3:0] lv,
                              input logic e, input logic ud, input logic clr,
                              input logic [3:0] cnt, input logic tc,
                              input logic wr, input logic ov);
    vec_t v;
    v.rst = rst; v.ld = ld; v.lv = lv; v.e = e; v.ud = ud; v.clr = clr;
    v.cnt = cnt; v.tc = tc; v.wr = wr; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic [3:0] lv,
                       input logic e, input logic ud, input logic clr);
    reset = rst; load = ld; load_val = lv; en = e; up_dn = ud; clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_c;

    reset = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b1; clr_ovf = 1'b0;

    // rst ld lv e ud clr | cnt tc wr ov
    vecs.push_back(mk(1, 0, 0, 0, 1, 0,  0, 0, 0, 0));   // reset, up: tc=0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 0, 0));   // reset, down: tc=1
    // wrap up: 12 enabled up steps
    for (int unsigned i = 1; i <= 12; i++) begin
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 4'((i) % 10), (i == 9) ? 1'b1 : 1'b0,
                        (i == 10) ? 1'b1 : 1'b0, (i >= 10) ? 1'b1 : 1'b0));
    end
    // sticky clear race
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,  2, 0, 0, 0));   // clear overflow
    vecs.push_back(mk(0, 1, 8, 1, 1, 0,  8, 0, 0, 0));   // load beats en
    vecs.push_back(mk(0, 0, 0, 1, 1, 0,  9, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1,  0, 0, 1, 1));   // wrap with clr: stays set
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 0));   // clr next cycle
    // down and clamp
    vecs.push_back(mk(0, 1, 2, 0, 0, 0,  2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,  9, 0, 1, 1));   // down wrap 0 -> 9
    vecs.push_back(mk(0, 1, 15, 1, 0, 0, 9, 0, 0, 1));   // clamp, no wrap_p
    vecs.push_back(mk(0, 1, 15, 0, 1, 0, 9, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,  9, 1, 0, 1));   // hold with en=0
    // reset priority over load/en with overflow set
    vecs.push_back(mk(1, 1, 5, 1, 1, 0,  0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].e, vecs[i].ud, vecs[i].clr);
      chk($sformatf("v%0d count", i), a_count, vecs[i].cnt);
      chk($sformatf("v%0d tc", i), a_tc, vecs[i].tc);
      chk($sformatf("v%0d wrap_p", i), a_wrap, vecs[i].wr);
      chk($sformatf("v%0d overflow", i), a_ovf, vecs[i].ov);
    end

    // Saturate mode: up count sticks at 9, every blocked step pulses wrap_p.
    drive(1, 0, 0, 0, 1, 0);
    for (int unsigned i = 1; i <= 12; i++) begin
      drive(0, 0, 0, 1, 1, 0);
      chk($sformatf("sat up %0d count", i), b_count, (i < 9) ? i : 9);
      chk($sformatf("sat up %0d wrap_p", i), b_wrap, (i >= 10) ? 1 : 0);
      chk($sformatf("sat up %0d overflow", i), b_ovf, (i >= 10) ? 1 : 0);
    end
    chk("sat tc at max", b_tc, 1);
    drive(0, 1, 1, 0, 0, 1);
    chk("sat load count", b_count, 1);
    chk("sat load overflow cleared", b_ovf, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("sat dn to 0 count", b_count, 0);
    chk("sat dn to 0 wrap_p", b_wrap, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("sat dn blocked count", b_count, 0);
    chk("sat dn blocked wrap_p", b_wrap, 1);
    chk("sat dn blocked overflow", b_ovf, 1);

    // Prescaler=3: en gaps delay the next step by the gap length.
    drive(1, 0, 0, 0, 1, 0);
    chk("presc reset count", c_count, 0);
    begin
      logic       en_pat  [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
      logic [3:0] cnt_pat [11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};
      for (int unsigned i = 0; i < 11; i++) begin
        drive(0, 0, 0, en_pat[i], 1, 0);
        chk($sformatf("presc cyc%0d count", i + 1), c_count, cnt_pat[i]);
      end
    end
    // load mid-phase restarts prescaler: next step three enabled cycles later
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 1, 5, 1, 1, 0);
    chk("presc load count", c_count, 5);
    exp_c = 4'd5;
    for (int unsigned i = 1; i <= 3; i++) begin
      drive(0, 0, 0, 1, 1, 0);
      if (i == 3) exp_c = 4'd6;
      chk($sformatf("presc after load %0d count", i), c_count, exp_c);
    end
    chk("presc wrap_p idle", c_wrap, 0);
    chk("presc overflow idle", c_ovf, 0);
    chk("presc tc", c_tc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
